dmem_arbiter: RTL

Two-requester arbiter that shares the single data-memory port between the core load/store unit and a host port. The host port preloads test arrays (e.g. the bubble-sort input) and reads back results. The block sits between core/host and dmem, and drives the memory enable, address, data and byte-enable signals. It issues at most one memory access per cycle and returns read data one cycle later to whichever requester owned the access.

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter_rr_arb2.sv | 74 +++++++
 rtl/dmem_arbiter.sv | 82 ++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding and default widths.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } owner_t;

  localparam int DMEM_ADDR_W   = 32;
  localparam int DMEM_DATA_W   = 32;
  localparam int DMEM_LOCK_MAX = 8;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_CORE) ? OWNER_HOST : OWNER_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, host and memory signals around the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a requester holds *_req high with stable we/addr/wdata/be until it
  // sees *_gnt=1 in the same cycle; that cycle is the transfer. Read data is
  // returned with *_rvalid=1 exactly one cycle after the granting cycle.
  logic                  core_req;
  logic                  core_we;
  logic [ADDR_W-1:0]     core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [DATA_W/8-1:0]   core_be;
  logic                  core_gnt;
  logic                  core_rvalid;
  logic [DATA_W-1:0]     core_rdata;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_W-1:0]     host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic [DATA_W/8-1:0]   host_be;
  logic                  host_lock;
  logic                  host_gnt;
  logic                  host_rvalid;
  logic [DATA_W-1:0]     host_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_be,
    input  host_req, host_we, host_addr, host_wdata, host_be, host_lock,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_be,
    output host_req, host_we, host_addr, host_wdata, host_be, host_lock,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant; host_lock lets the host keep ownership for up to
// LOCK_MAX extra grants while the core waits.
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = DMEM_LOCK_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic core_req_i,
  input  logic host_req_i,
  input  logic host_lock_i,
  output logic core_gnt_o,
  output logic host_gnt_o
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  owner_t           last_owner_q, last_owner_d;
  logic             host_lock_q, host_lock_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_active;
  owner_t           tie_winner;

  always_comb begin
    lock_active = (last_owner_q == OWNER_HOST) && host_lock_q &&
                  (lock_cnt_q < CNT_W'(LOCK_MAX));
    tie_winner  = lock_active ? OWNER_HOST : other_owner(last_owner_q);

    // Grants are forced low while reset is held, independent of the requests.
    core_gnt_o = 1'b0;
    host_gnt_o = 1'b0;
    if (!rst) begin
      if (core_req_i && host_req_i) begin
        core_gnt_o = (tie_winner == OWNER_CORE);
        host_gnt_o = (tie_winner == OWNER_HOST);
      end else begin
        core_gnt_o = core_req_i;
        host_gnt_o = host_req_i;
      end
    end

    last_owner_d = last_owner_q;
    host_lock_d  = host_lock_q;
    lock_cnt_d   = lock_cnt_q;
    if (core_gnt_o) begin
      last_owner_d = OWNER_CORE;
      host_lock_d  = 1'b0;
      lock_cnt_d   = '0;
    end else if (host_gnt_o) begin
      last_owner_d = OWNER_HOST;
      host_lock_d  = host_lock_i;
      if (!host_lock_q)
        lock_cnt_d = '0;
      else if (core_req_i && lock_active)
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end else if (!host_lock_q) begin
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OWNER_HOST;
      host_lock_q  <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      host_lock_q  <= host_lock_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core LSU and the host port,
// muxing the winner onto mem_* and routing read data back one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int LOCK_MAX = DMEM_LOCK_MAX
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_W / 8;

  logic              core_gnt, host_gnt, gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q;
  logic [BE_W-1:0]   sel_be, be_q;
  logic              rd_pending_q, rd_pending_d;
  owner_t            rd_owner_q, rd_owner_d;
  logic              core_rvalid, host_rvalid;

  rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .core_req_i  (bus.core_req),
    .host_req_i  (bus.host_req),
    .host_lock_i (bus.host_lock),
    .core_gnt_o  (core_gnt),
    .host_gnt_o  (host_gnt)
  );

  always_comb begin
    gnt_any   = core_gnt | host_gnt;
    sel_we    = host_gnt ? bus.host_we    : bus.core_we;
    sel_addr  = host_gnt ? bus.host_addr  : bus.core_addr;
    sel_wdata = host_gnt ? bus.host_wdata : bus.core_wdata;
    sel_be    = host_gnt ? bus.host_be    : bus.core_be;

    rd_pending_d = gnt_any && !sel_we;
    rd_owner_d   = rd_pending_d ? (host_gnt ? OWNER_HOST : OWNER_CORE) : rd_owner_q;
  end

  // Address/data/be hold their last granted value so idle cycles do not toggle the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWNER_CORE;
    end else begin
      if (gnt_any) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        be_q    <= sel_be;
      end
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign core_rvalid = rd_pending_q && (rd_owner_q == OWNER_CORE);
  assign host_rvalid = rd_pending_q && (rd_owner_q == OWNER_HOST);

  assign bus.core_gnt    = core_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.core_rvalid = core_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.core_rdata  = core_rvalid ? bus.mem_rdata : '0;
  assign bus.host_rdata  = host_rvalid ? bus.mem_rdata : '0;

  assign bus.mem_en    = gnt_any;
  assign bus.mem_we    = gnt_any && sel_we;
  assign bus.mem_addr  = gnt_any ? sel_addr  : addr_q;
  assign bus.mem_wdata = gnt_any ? sel_wdata : wdata_q;
  assign bus.mem_be    = gnt_any ? sel_be    : be_q;

endmodule
